// File: rtl/exhaust_status_display.sv
`default_nettype none
// ============================================================================
// Module   : exhaust_status_display
// Purpose  : Display-side consumer of the exhaust controller status. Drives a
//            4-digit multiplexed seven-segment display and four mode LEDs.
//            The countdown is converted to BCD by a free-running sequential
//            double-dabble converter; countdowns of 10 s or less blink.
// Ports    : clk              - system clock
//            rst              - asynchronous active-high reset
//            mode[1:0]        - controller mode (idle/level1/level2/level3)
//            countdown[7:0]   - countdown in seconds, unsigned
//            countdown_active - countdown value is meaningful
//            busy             - fan running (shown as dp of leftmost digit)
//            an[3:0]          - one-hot digit enables, an[3] = leftmost
//            seg[7:0]         - segments {dp,g,f,e,d,c,b,a}, active-high
//            led[3:0]         - one-hot mode LEDs
// Revision : 1.0 - initial release
// ============================================================================
module exhaust_status_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] countdown,
  input  logic       countdown_active,
  input  logic       busy,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic [3:0] led
);

  localparam int c_SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] c_GLYPH_R     = 7'h50;
  localparam logic [6:0] c_GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Digit value to segment pattern (without dp).
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = c_GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // --------------------------------------------------------------------------
  // BCD converter
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [2:0]  r_shift_cnt;
  logic [7:0]  r_bin;       // shifting copy of the sample
  logic [7:0]  r_cap;       // untouched copy of the sample, for disp_val
  logic [11:0] r_bcd;       // scratch
  logic [3:0]  r_hund;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;
  logic [7:0]  r_disp_val;
  logic [11:0] w_adj;

  // Add-3 correction applied to each nibble before the shift.
  always_comb begin
    w_adj = r_bcd;
    if (r_bcd[3:0]  >= 4'd5) w_adj[3:0]  = r_bcd[3:0]  + 4'd3;
    if (r_bcd[7:4]  >= 4'd5) w_adj[7:4]  = r_bcd[7:4]  + 4'd3;
    if (r_bcd[11:8] >= 4'd5) w_adj[11:8] = r_bcd[11:8] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_shift_cnt <= 3'd0;
      r_bin       <= 8'd0;
      r_cap       <= 8'd0;
      r_bcd       <= 12'd0;
      r_hund      <= 4'd0;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_disp_val  <= 8'd0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_bin       <= countdown;
          r_cap       <= countdown;
          r_bcd       <= 12'd0;
          r_shift_cnt <= 3'd0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_shift_cnt    <= r_shift_cnt + 3'd1;
          if (r_shift_cnt == 3'd7) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // Digits and disp_val are taken together so they always agree.
          r_hund     <= r_bcd[11:8];
          r_tens     <= r_bcd[7:4];
          r_ones     <= r_bcd[3:0];
          r_disp_val <= r_cap;
          r_state    <= ST_LOAD;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scan and blink timebases (free-running)
  // --------------------------------------------------------------------------
  logic [c_SCAN_W-1:0]  r_scan_cnt;
  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic [1:0]           r_digit;
  logic                 r_blink_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_digit     <= 2'd0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      if (r_scan_cnt == c_SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_digit    <= r_digit + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
      end
      if (r_blink_cnt == c_BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Glyph selection
  // --------------------------------------------------------------------------
  logic       w_blank_cd;
  logic [7:0] w_seg_next;
  logic [3:0] w_an_next;
  logic [3:0] w_led_next;

  assign w_blank_cd = countdown_active & (r_disp_val <= 8'd10) & ~r_blink_on;

  always_comb begin
    w_seg_next = 8'h00;
    w_an_next  = 4'b0001 << r_digit;
    w_led_next = 4'b0001 << mode;
    case (r_digit)
      2'd0: begin
        if (countdown_active && !w_blank_cd)
          w_seg_next = {1'b0, glyph(r_ones)};
      end
      2'd1: begin
        // Leading-zero suppression: tens hidden only if hundreds is also 0.
        if (countdown_active && !w_blank_cd &&
            !(r_hund == 4'd0 && r_tens == 4'd0))
          w_seg_next = {1'b0, glyph(r_tens)};
      end
      2'd2: begin
        if (countdown_active && !w_blank_cd && r_hund != 4'd0)
          w_seg_next = {1'b0, glyph(r_hund)};
      end
      default: begin
        // Idle with an active countdown means return-to-idle: show 'r'.
        if (mode == 2'b00 && countdown_active)
          w_seg_next = {busy, c_GLYPH_R};
        else
          w_seg_next = {busy, glyph({2'b00, mode})};
      end
    endcase
  end

  logic [3:0] r_an;
  logic [7:0] r_seg;
  logic [3:0] r_led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b0000;
      r_seg <= 8'h00;
      r_led <= 4'b0000;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_led <= w_led_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign led = r_led;

endmodule
`default_nettype wire

// File: tb/tb_exhaust_status_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_exhaust_status_display
// Purpose  : Directed self-checking bench for exhaust_status_display. A second
//            instance with a blink period that drifts against the scan lets
//            the ones digit be seen in both blink phases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exhaust_status_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] countdown;
  logic       countdown_active;
  logic       busy;
  logic [3:0] an, led, an_b, led_b;
  logic [7:0] seg, seg_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc;     // clock edges since the last reset release

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  exhaust_status_display #(.SCAN_DIV(4), .BLINK_DIV(8)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .countdown(countdown),
    .countdown_active(countdown_active), .busy(busy),
    .an(an), .seg(seg), .led(led)
  );

  exhaust_status_display #(.SCAN_DIV(4), .BLINK_DIV(12)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .countdown(countdown),
    .countdown_active(countdown_active), .busy(busy),
    .an(an_b), .seg(seg_b), .led(led_b)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the main DUT to scan the given digit, then check seg.
  task automatic dig(input string tag, input logic [3:0] which, input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    while (an !== which && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an !== which) chk({tag, "_timeout"}, {4'h0, an}, {4'h0, which});
    else              chk(tag, seg, exp);
  endtask

  // Instance B: blink_on after edge m is ((m/12)%2==0); outputs after edge e
  // reflect state after edge e-1.
  task automatic blink_b(input string tag, input logic [7:0] e1, input logic [7:0] e0,
                         input bit blinks);
    bit on;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      on = (((cyc - 1) / 12) % 2) == 0;
      if (an_b == 4'b0001)
        chk({tag, "_b_d0"}, seg_b, (blinks && !on) ? 8'h00 : e0);
      else if (an_b == 4'b0010)
        chk({tag, "_b_d1"}, seg_b, (blinks && !on) ? 8'h00 : e1);
    end
  endtask

  initial begin
    bit legal;
    rst = 1'b1; mode = 2'b00; countdown = 8'd0; countdown_active = 1'b0; busy = 1'b0;

    // 1. Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_an",  {4'h0, an},  8'h00);
    chk("rst_seg", seg,         8'h00);
    chk("rst_led", {4'h0, led}, 8'h00);
    chk("rst_an_b", {4'h0, an_b}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an",  {4'h0, an},  8'h01);
    chk("first_seg", seg,         8'h00);
    chk("idle_led",  {4'h0, led}, 8'h01);
    for (int k = 1; k < 4; k++) begin
      repeat (4) @(negedge clk);
      chk("rot_an", {4'h0, an}, 8'h01 << k);
    end
    chk("idle_d3_now", seg, 8'h3F);
    dig("idle_d3", 4'b1000, 8'h3F);
    dig("idle_d2", 4'b0100, 8'h00);
    dig("idle_d1", 4'b0010, 8'h00);
    dig("idle_d0", 4'b0001, 8'h00);

    // 2. Level 3, countdown 200
    mode = 2'b11; countdown = 8'd200; countdown_active = 1'b1; busy = 1'b1;
    repeat (22) @(negedge clk);
    dig("l3_d2", 4'b0100, 8'h5B);
    dig("l3_d1", 4'b0010, 8'h3F);
    dig("l3_d0", 4'b0001, 8'h3F);
    dig("l3_d3", 4'b1000, 8'hCF);
    chk("l3_led",   {4'h0, led},   8'h08);
    chk("l3_led_b", {4'h0, led_b}, 8'h08);

    // 3. Return-to-idle, countdown 60
    mode = 2'b00; countdown = 8'd60; busy = 1'b0;
    repeat (22) @(negedge clk);
    dig("rti_d3", 4'b1000, 8'h50);
    dig("rti_d2", 4'b0100, 8'h00);
    dig("rti_d1", 4'b0010, 8'h7D);
    dig("rti_d0", 4'b0001, 8'h3F);
    chk("rti_led", {4'h0, led}, 8'h01);

    // 4. Final-seconds blink, countdown 7
    countdown = 8'd7;
    repeat (22) @(negedge clk);
    dig("cd7_d2", 4'b0100, 8'h00);
    dig("cd7_d1", 4'b0010, 8'h00);
    dig("cd7_d0", 4'b0001, 8'h07);
    dig("cd7_d3a", 4'b1000, 8'h50);
    dig("cd7_d3b", 4'b1000, 8'h50);
    blink_b("cd7", 8'h00, 8'h07, 1'b1);

    // 5. Boundary values
    countdown = 8'd255;
    repeat (22) @(negedge clk);
    dig("cd255_d2", 4'b0100, 8'h5B);
    dig("cd255_d1", 4'b0010, 8'h6D);
    dig("cd255_d0", 4'b0001, 8'h6D);
    countdown = 8'd10;
    repeat (22) @(negedge clk);
    dig("cd10_d1", 4'b0010, 8'h06);
    dig("cd10_d0", 4'b0001, 8'h3F);
    blink_b("cd10", 8'h06, 8'h3F, 1'b1);
    countdown = 8'd11;
    repeat (22) @(negedge clk);
    dig("cd11_d1", 4'b0010, 8'h06);
    dig("cd11_d0", 4'b0001, 8'h06);
    blink_b("cd11", 8'h06, 8'h06, 1'b0);
    countdown = 8'd0;
    repeat (22) @(negedge clk);
    dig("cd0_d1", 4'b0010, 8'h00);
    dig("cd0_d0", 4'b0001, 8'h3F);
    blink_b("cd0", 8'h00, 8'h3F, 1'b1);

    // 6. Reset mid-conversion (state after edge e: SHIFT for e%10 in 1..8)
    countdown = 8'd123;
    repeat (22) @(negedge clk);
    dig("pre_d0", 4'b0001, 8'h4F);
    for (int i = 0; i < 12 && (cyc % 10) != 4; i++) @(negedge clk);
    chk("mid_phase", 8'((cyc % 10)), 8'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_an",  {4'h0, an},  8'h00);
    chk("mid_rst_seg", seg,         8'h00);
    chk("mid_rst_led", {4'h0, led}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc >= 22) begin
        if (an == 4'b0001) chk("post_d0", seg, 8'h4F);
        if (an == 4'b0010) chk("post_d1", seg, 8'h5B);
        if (an == 4'b0100) chk("post_d2", seg, 8'h06);
      end else begin
        legal = 1'b1;
        if (an == 4'b0001) legal = (seg == 8'h3F || seg == 8'h00 || seg == 8'h4F);
        if (an == 4'b0010) legal = (seg == 8'h00 || seg == 8'h5B);
        if (an == 4'b0100) legal = (seg == 8'h00 || seg == 8'h06);
        chk("no_partial", {7'h0, legal}, 8'h01);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exhaust_status_display.md
# exhaust_status_display

Display-side consumer of the exhaust controller's status outputs (mode, countdown, busy, countdown_active). It drives the board's 4-digit multiplexed seven-segment display and four mode LEDs. It sits between the exhaust controller and the top-level pins. Countdown binary is converted to BCD with a sequential double-dabble converter, and the last 10 seconds of any countdown blink.

## Interface
- SCAN_DIV, 50000: clk cycles each digit is held during scanning; must be ≥2.
- BLINK_DIV, 25000000: clk cycles per blink half-period; must be ≥2.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  2  controller mode: 00 idle, 01 level1, 10 level2, 11 level3.
- countdown  input  8  controller countdown, unsigned seconds.
- countdown_active  input  1  countdown valid (level3 or return-to-idle).
- busy  input  1  fan running.
- an  output  4  digit enables, active-high, one-hot; an[3] is the leftmost digit.
- seg  output  8  segments, active-high, {dp,g,f,e,d,c,b,a}.
- led  output  4  mode LEDs, one-hot, led[mode]=1.

## Operation
- Glyphs (hex, without dp): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, r=50, blank=00.
- **BCD converter FSM**, free-running with states LOAD, SHIFT, COMMIT:
  - LOAD: capture countdown into an 8-bit shift register and clear a 12-bit BCD scratch register; go to SHIFT with shift count 0.
  - SHIFT: 8 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1.
  - COMMIT: copy the scratch register to the displayed hundreds/tens/ones registers. Also copy the captured binary into disp_val. Return to LOAD.
  - Conversion period is 10 cycles. Displayed digits and disp_val always belong to the same sample; no torn values.
- **Scan counter** counts 0..SCAN_DIV-1. On wrap, digit index advances 0→1→2→3→0. Index 0 is the rightmost digit (ones).
- **Blink**: blink counter counts 0..BLINK_DIV-1 and toggles blink_on on wrap. blink_on resets to 1.
  - blank_cd = countdown_active & (disp_val ≤ 10) & ~blink_on.
- **Per-digit glyph**:
  - digit3: if mode==00 and countdown_active, show 'r' (return-to-idle indicator); otherwise show the glyph of mode value 0–3. dp = busy.
  - digit2 (hundreds): blank if ~countdown_active, hundreds==0, or blank_cd.
  - digit1 (tens): blank if ~countdown_active, (hundreds==0 & tens==0), or blank_cd.
  - digit0 (ones): blank if ~countdown_active or blank_cd. Value 0 shows "0".
  - dp is 0 on digits 0–2.
- led = one-hot decode of mode (00→0001, 01→0010, 10→0100, 11→1000), independent of countdown_active.

## Timing
- Reset values: an=0000, seg=00, led=0000, BCD/disp_val=0, converter in LOAD, scan/blink counters 0, digit index 0, blink_on=1.
- an, seg, led are registered and update 1 cycle after their inputs/index change. First cycle after reset release: an=0001.
- Countdown latency: a stable countdown appears in the BCD registers ≤20 cycles after it changes (worst case: just missed LOAD).
- mode, busy, countdown_active take effect on seg/led 1 cycle later (not routed through the converter).
- Scan and blink counters are free-running and not restarted by input changes.
- Reset mid-conversion: the scratch register is discarded and the displayed BCD is cleared immediately (asynchronous).
- countdown=0 with countdown_active=1 displays "0" and blinks.
- Counter widths: ceil(log2(SCAN_DIV)) and ceil(log2(BLINK_DIV)); the terminal compare is exact, with no overflow at the maximum.

## Test plan
Benches run with SCAN_DIV=4 and BLINK_DIV=8.
1. **Reset and idle.** Hold rst, then release with mode=00, countdown_active=0, busy=0.
   - During reset, all outputs are 0.
   - After release: led=0001; digit3 seg=3F; digits 2..0 seg=00; an rotates 0001→0010→0100→1000 every 4 cycles.
2. **Level 3, countdown 200.** mode=11, countdown=200, countdown_active=1, busy=1.
   - Within 20 cycles: digit2=5B, digit1=3F, digit0=3F, digit3=CF; led=1000; no blanking.
3. **Return-to-idle, countdown 60.** mode=00, countdown_active=1, countdown=60.
   - digit3=50, digit2=00, digit1=7D, digit0=3F; led=0001.
4. **Final-seconds blink, countdown 7.** countdown=7, countdown_active=1.
   - digits 2 and 1 read 00.
   - digit0 reads 07 while blink_on and 00 while not; the phase toggles every 8 cycles. digit3 does not blink.
5. **Boundary values.** countdown 255, then 10, then 11, then 0.
   - 255 shows 5B/6D/6D.
   - 10 shows tens 06 and ones 3F, blinking.
   - 11 shows 06/06, steady.
   - 0 shows ones 3F, blinking.
6. **Reset mid-conversion.** Assert rst 3 cycles into SHIFT while countdown=123.
   - Outputs clear immediately.
   - After release, 123 is displayed (06/5B/4F) within 20 cycles; no partial value is ever shown.
